nios_audio_system_audio_out_fifo: RTL and testbench

- Avalon-MM slave on the NIOS data master; the playback counterpart of the audio input PIO.
- Software writes 16-bit samples into a small FIFO.
- The codec-side sample_tick pops one sample per audio frame onto out_port.
- Provides status, underrun/overflow flags, an underrun counter and a low-water interrupt so the CPU can refill in bursts.

---
 rtl/nios_audio_out_pkg.sv | 21 ++
 rtl/nios_audio_system_audio_out_fifo_if.sv | 18 +
 rtl/nios_audio_system_sample_fifo.sv | 73 +++++++
 rtl/nios_audio_system_audio_out_fifo.sv | 141 ++++++++++++++
 tb/tb_nios_audio_system_audio_out_fifo.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_audio_out_pkg.sv
// Shared register map, bit positions and constants for the audio output FIFO peripheral.
package nios_audio_out_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_CONTROL  = 2'd2;
  localparam logic [1:0] ADDR_UNDERRUN = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERRUN  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam logic [15:0] UNDERRUN_SAT = 16'hFFFF;

endpackage

// File: rtl/nios_audio_system_audio_out_fifo_if.sv
// Avalon-MM slave bus bundle between the NIOS data master and the audio output FIFO.
interface nios_audio_system_audio_out_fifo_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_audio_system_sample_fifo.sv
// Synchronous sample FIFO with flush; full/empty come from the level counter, not pointer compare.
module nios_audio_system_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LEVEL_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]    level_q,  level_d;
  logic                  do_push, do_pop;

  assign full_o  = (level_q == LEVEL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/nios_audio_system_audio_out_fifo.sv
// Audio playback peripheral: CPU pushes samples over Avalon-MM, codec sample_tick pops them onto out_port.
module nios_audio_system_audio_out_fifo
  import nios_audio_out_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int LOW_WATER  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  nios_audio_system_audio_out_fifo_if.slave avs,
  input  logic                            sample_tick,
  output logic [DATA_WIDTH-1:0]           out_port,
  output logic                            sample_valid,
  output logic                            irq
);

  localparam int LEVEL_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] out_port_q,     out_port_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  irq_q,          irq_d;
  logic [31:0]           readdata_q,     readdata_d;
  logic                  enable_q,       enable_d;
  logic                  irq_en_q,       irq_en_d;
  logic                  overflow_q,     overflow_d;
  logic                  underrun_q,     underrun_d;
  logic [15:0]           underrun_cnt_q, underrun_cnt_d;

  logic                  wr_en, push, flush, tick_act, pop;
  logic                  underrun_evt, overflow_evt;
  logic                  clr_overflow, clr_underrun, clr_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  fifo_full, fifo_empty;
  logic [31:0]           status_word;
  logic                  unused_wdata;

  assign unused_wdata = ^avs.writedata[31:DATA_WIDTH];

  assign wr_en        = avs.chipselect & ~avs.write_n;
  assign push         = wr_en && (avs.address == ADDR_DATA);
  assign flush        = wr_en && (avs.address == ADDR_CONTROL) && avs.writedata[CTRL_FLUSH];
  // A flush swallows a coincident tick: nothing is popped and no underrun is charged.
  assign tick_act     = sample_tick & enable_q & ~flush;
  assign pop          = tick_act & ~fifo_empty;
  assign underrun_evt = tick_act & fifo_empty;
  assign overflow_evt = push & fifo_full & ~pop;

  assign clr_overflow = wr_en && (avs.address == ADDR_STATUS) && avs.writedata[STAT_OVERFLOW];
  assign clr_underrun = wr_en && (avs.address == ADDR_STATUS) && avs.writedata[STAT_UNDERRUN];
  assign clr_count    = wr_en && (avs.address == ADDR_UNDERRUN);

  nios_audio_system_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (avs.writedata[DATA_WIDTH-1:0]),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    status_word                                  = '0;
    status_word[STAT_EMPTY]                      = fifo_empty;
    status_word[STAT_FULL]                       = fifo_full;
    status_word[STAT_OVERFLOW]                   = overflow_q;
    status_word[STAT_UNDERRUN]                   = underrun_q;
    status_word[STAT_LEVEL_LSB +: LEVEL_W]       = fifo_level;
  end

  always_comb begin
    out_port_d     = pop ? fifo_head : out_port_q;
    sample_valid_d = pop;
    irq_d          = irq_en_q & enable_q & (fifo_level < LEVEL_W'(LOW_WATER));

    enable_d = enable_q;
    irq_en_d = irq_en_q;
    if (wr_en && (avs.address == ADDR_CONTROL)) begin
      enable_d = avs.writedata[CTRL_ENABLE];
      irq_en_d = avs.writedata[CTRL_IRQ_EN];
    end

    // Clear first, then set, so a fresh event beats a simultaneous W1C.
    overflow_d = (overflow_q & ~clr_overflow) | overflow_evt;
    underrun_d = (underrun_q & ~clr_underrun) | underrun_evt;

    underrun_cnt_d = clr_count ? 16'h0000 : underrun_cnt_q;
    if (underrun_evt && (underrun_cnt_d != UNDERRUN_SAT)) begin
      underrun_cnt_d = underrun_cnt_d + 16'h0001;
    end

    readdata_d = '0;
    case (avs.address)
      ADDR_DATA:     readdata_d[DATA_WIDTH-1:0] = out_port_q;
      ADDR_STATUS:   readdata_d = status_word;
      ADDR_CONTROL: begin
        readdata_d[CTRL_ENABLE] = enable_q;
        readdata_d[CTRL_IRQ_EN] = irq_en_q;
      end
      default:       readdata_d[15:0] = underrun_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port_q     <= '0;
      sample_valid_q <= 1'b0;
      irq_q          <= 1'b0;
      readdata_q     <= '0;
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      overflow_q     <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      out_port_q     <= out_port_d;
      sample_valid_q <= sample_valid_d;
      irq_q          <= irq_d;
      readdata_q     <= readdata_d;
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      overflow_q     <= overflow_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign out_port     = out_port_q;
  assign sample_valid = sample_valid_q;
  assign irq          = irq_q;
  assign avs.readdata = readdata_q;

endmodule

// File: tb/tb_nios_audio_system_audio_out_fifo.sv
// Directed plus randomized bench for the audio output FIFO, checked against a queue-based model.
module tb_nios_audio_system_audio_out_fifo;

  logic        clk;
  logic        reset_n;
  logic        sample_tick;
  logic [15:0] out_port;
  logic        sample_valid;
  logic        irq;

  nios_audio_system_audio_out_fifo_if bus ();

  nios_audio_system_audio_out_fifo #(
    .DATA_WIDTH (16),
    .DEPTH_LOG2 (4),
    .LOW_WATER  (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs          (bus),
    .sample_tick  (sample_tick),
    .out_port     (out_port),
    .sample_valid (sample_valid),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] mq [$];
  logic        m_en, m_ien, m_ovf, m_und;
  logic [15:0] m_cnt, m_out;
  logic [31:0] e_rd;
  logic        e_sv, e_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_ien = 0; m_ovf = 0; m_und = 0;
    m_cnt = 0; m_out = 0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(mq.size()) << 8;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == 16);
    s[2] = m_ovf;
    s[3] = m_und;
    return s;
  endfunction

  // One bus cycle: drive, predict from the rules, clock, compare.
  task automatic step(input logic cs, input logic [1:0] a, input logic wr,
                      input logic [31:0] wd, input logic tk);
    logic we, flush, etick, popped, und_evt, ovf_evt;
    bus.chipselect = cs; bus.address = a; bus.write_n = ~wr;
    bus.writedata = wd; sample_tick = tk;

    case (a)
      2'd0: e_rd = {16'h0, m_out};
      2'd1: e_rd = m_status();
      2'd2: e_rd = {29'h0, m_ien, 1'b0, m_en};
      default: e_rd = {16'h0, m_cnt};
    endcase
    e_irq = m_ien & m_en & (mq.size() < 8);

    we      = cs & wr;
    flush   = we && a == 2'd2 && wd[1];
    etick   = tk && m_en && !flush;
    popped  = etick && mq.size() > 0;
    und_evt = etick && mq.size() == 0;
    ovf_evt = 0;
    if (flush) mq.delete();
    if (popped) m_out = mq.pop_front();
    e_sv = popped;
    if (we && a == 2'd0) begin
      if (mq.size() < 16) mq.push_back(wd[15:0]);
      else ovf_evt = 1;
    end
    if (we && a == 2'd1 && wd[2]) m_ovf = 0;
    if (we && a == 2'd1 && wd[3]) m_und = 0;
    if (ovf_evt) m_ovf = 1;
    if (und_evt) m_und = 1;
    if (we && a == 2'd3) m_cnt = 0;
    if (und_evt && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (we && a == 2'd2) begin
      m_en = wd[0];
      m_ien = wd[2];
    end

    @(posedge clk);
    #1;
    chk("readdata", bus.readdata, e_rd);
    chk("out_port", {16'h0, out_port}, {16'h0, m_out});
    chk("sample_valid", {31'h0, sample_valid}, {31'h0, e_sv});
    chk("irq", {31'h0, irq}, {31'h0, e_irq});
    $display("step cs=%0b a=%0d wr=%0b wd=%h tick=%0b -> rd=%h out=%h sv=%0b irq=%0b lvl=%0d",
             cs, a, wr, wd, tk, bus.readdata, out_port, sample_valid, irq, mq.size());
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    step(1'b1, a, 1'b1, wd, 1'b0);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    step(1'b1, a, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    sample_tick = 0;
    bus.chipselect = 0; bus.address = 0; bus.write_n = 1; bus.writedata = 0;
    model_reset();
    #3;
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_out_port", {16'h0, out_port}, 32'h0);
    chk("rst_sample_valid", {31'h0, sample_valid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: register reads after reset
    rd_reg(2'd0); chk("t1_data", bus.readdata, 32'h0);
    rd_reg(2'd1); chk("t1_status", bus.readdata, 32'h1);
    rd_reg(2'd2); chk("t1_control", bus.readdata, 32'h0);
    rd_reg(2'd3); chk("t1_count", bus.readdata, 32'h0);

    // 2: two samples played out
    wr_reg(2'd2, 32'h1);
    wr_reg(2'd0, 32'h1234);
    wr_reg(2'd0, 32'hABCD);
    tick(); chk("t2_out0", {16'h0, out_port}, 32'h1234);
    chk("t2_sv0", {31'h0, sample_valid}, 32'h1);
    idle(); chk("t2_sv_gap", {31'h0, sample_valid}, 32'h0);
    tick(); chk("t2_out1", {16'h0, out_port}, 32'hABCD);
    rd_reg(2'd1); chk("t2_status", bus.readdata, 32'h1);

    // 3: overfill by one, then drain in order
    for (int i = 1; i <= 17; i++) wr_reg(2'd0, 32'(i));
    rd_reg(2'd1); chk("t3_status_full", bus.readdata, 32'h1006);
    wr_reg(2'd1, 32'h4);
    for (int i = 1; i <= 16; i++) begin
      tick(); chk("t3_drain", {16'h0, out_port}, 32'(i));
    end

    // 4: underrun on empty FIFO
    repeat (3) tick();
    chk("t4_hold", {16'h0, out_port}, 32'h10);
    rd_reg(2'd3); chk("t4_count", bus.readdata, 32'h3);
    rd_reg(2'd1); chk("t4_status", bus.readdata, 32'h9);
    wr_reg(2'd1, 32'h8);
    rd_reg(2'd1); chk("t4_status_clr", bus.readdata, 32'h1);
    wr_reg(2'd3, 32'h0);
    rd_reg(2'd3); chk("t4_count_clr", bus.readdata, 32'h0);

    // 5: push+pop while full, flush against a tick
    for (int i = 0; i < 16; i++) wr_reg(2'd0, 32'h100 + 32'(i));
    step(1'b1, 2'd0, 1'b1, 32'h55AA, 1'b1);
    chk("t5_pop_full", {16'h0, out_port}, 32'h100);
    rd_reg(2'd1); chk("t5_status_full", bus.readdata, 32'h1002);
    step(1'b1, 2'd2, 1'b1, 32'h3, 1'b1);
    chk("t5_flush_sv", {31'h0, sample_valid}, 32'h0);
    rd_reg(2'd1); chk("t5_status_flush", bus.readdata, 32'h1);
    rd_reg(2'd3); chk("t5_count", bus.readdata, 32'h0);

    // 6: low-water interrupt
    wr_reg(2'd2, 32'h5);
    for (int i = 0; i < 8; i++) wr_reg(2'd0, 32'h200 + 32'(i));
    idle(); chk("t6_irq_at8", {31'h0, irq}, 32'h0);
    tick();
    idle(); chk("t6_irq_at7", {31'h0, irq}, 32'h1);
    wr_reg(2'd2, 32'h4);
    idle(); chk("t6_irq_disabled", {31'h0, irq}, 32'h0);
    repeat (3) tick();
    rd_reg(2'd3); chk("t6_count_same", bus.readdata, 32'h0);
    rd_reg(2'd1); chk("t6_level_same", bus.readdata, 32'h700);

    // Randomized traffic
    wr_reg(2'd2, 32'h5);
    for (int n = 0; n < 400; n++) begin
      logic        cs, w, tk;
      logic [1:0]  a;
      logic [31:0] wd;
      int          r;
      r  = $urandom_range(0, 99);
      wd = $urandom;
      tk = ($urandom_range(0, 2) == 0);
      if (r < 40) begin
        cs = 1; w = 1; a = 2'd0;
      end else begin
        cs = (r < 75);
        w  = ($urandom_range(0, 2) == 0);
        a  = 2'($urandom_range(0, 3));
      end
      if (a == 2'd2) begin
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 9) == 0);
      end
      step(cs, a, w, wd, tk);
    end

    // Asynchronous reset mid-operation
    wr_reg(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) wr_reg(2'd0, 32'h300 + 32'(i));
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out", {16'h0, out_port}, 32'h0);
    chk("mid_rst_rd", bus.readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_reg(2'd1); chk("mid_rst_status", bus.readdata, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
